// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable frame format, 2-of-3 mid-bit vote,
// false-start rejection, parity/framing/break/overrun flags, valid/ready output.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] C_LO  = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_HI  = CW'(M + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BRK_WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 meta_q, rxs_q;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 par_q, par_d, zero_q, zero_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, perr_q, perr_d;
    logic                 fe_q, fe_d, ovr_q, ovr_d, brk_q, brk_d;
    logic                 maj, hi_tick, wrap, done, perr_calc;

    assign maj     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign hi_tick = sample_tick && (cnt_q == C_HI);
    assign wrap    = sample_tick && (cnt_q == C_END);

    assign perr_calc = (PARITY_MODE == 1) ? par_q :
                       (PARITY_MODE == 2) ? ~par_q : 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        par_d   = par_q;
        zero_d  = zero_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        brk_d   = 1'b0;
        done    = 1'b0;

        if (sample_tick && state_q != IDLE && state_q != BRK_WAIT) begin
            cnt_d = (cnt_q == C_END) ? '0 : cnt_q + 1'b1;
            if (cnt_q == C_LO)  s0_d = rxs_q;
            if (cnt_q == C_MID) s1_d = rxs_q;
        end

        unique case (state_q)
            IDLE: begin
                if (sample_tick && !rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    zero_d  = 1'b1;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (hi_tick && maj) state_d = IDLE;
                else if (wrap)      state_d = DATA;
            end
            DATA: begin
                if (hi_tick) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ maj;
                    zero_d  = zero_q & ~maj;
                end
                if (wrap) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (hi_tick) begin
                    par_d  = par_q ^ maj;
                    zero_d = zero_q & ~maj;
                end
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // leave at the last stop bit's vote to absorb baud drift
                if (hi_tick) begin
                    if (!maj) ferr_d = 1'b1;
                    if (bit_q == '0 && zero_q && !maj) begin
                        brk_d   = 1'b1;
                        state_d = BRK_WAIT;
                    end else if (bit_q == 4'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end else if (wrap) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            BRK_WAIT: begin
                if (sample_tick && rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && rx_ready) valid_d = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                perr_d  = perr_calc;
                fe_d    = ferr_q | ~maj;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            par_q   <= 1'b0;
            zero_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            meta_q  <= rx;
            rxs_q   <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            par_q   <= par_d;
            zero_q  <= zero_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign rx_break   = brk_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver for the serial security-wrapper datapath. It replaces the fixed 8-bit, one-sample-per-bit receiver. The block adds configurable frame format, mid-bit majority voting, false-start rejection, parity/framing/break/overrun detection, and a valid/ready output handshake toward the wrapper logic. It sits between the pad-level `rx` line and the message/integrity checker, clocked from the 3.125 MHz system clock, and is driven by a shared oversampling tick generator.

## Interface
- `DATA_BITS`, 8 — data bits per frame, legal 5..9, LSB first.
- `PARITY_MODE`, 1 — 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1 — 1 or 2.
- `OVERSAMPLE`, 16 — `sample_tick` pulses per bit; even, legal 8..32.
- `clk_3125` input 1 — system clock; all logic on its rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `sample_tick` input 1 — single-cycle enable at `OVERSAMPLE` × baud.
- `rx` input 1 — asynchronous serial line, idle high.
- `rx_ready` input 1 — consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data` output `DATA_BITS` — received word.
- `rx_valid` output 1 — `rx_data` and error flags hold a frame.
- `parity_err` output 1 — parity mismatch for the held frame (0 when `PARITY_MODE` = 0).
- `frame_err` output 1 — a stop bit of the held frame sampled 0.
- `overrun` output 1 — one-cycle pulse; a completed frame was dropped.
- `rx_break` output 1 — one-cycle pulse; break condition detected.
- `rx_busy` output 1 — high in any state other than IDLE.

## Operation
- Synchronise `rx` through two flops, both reset to 1. All decisions use the synchronised value `rxs`.
- Let M = `OVERSAMPLE`/2. The tick counter `cnt` advances only on `sample_tick` and wraps at `OVERSAMPLE`-1 to 0, which marks the next bit.
- **Bit decision:** capture `rxs` on the ticks at `cnt` = M-1, M and M+1. The bit value is the 2-of-3 majority, decided on the M+1 tick.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- **IDLE:** on a `sample_tick` with `rxs` = 0, clear `cnt` to 0 and go to START.
- **START:**
  - If the majority at M+1 is 1, this is a false start: return to IDLE, with no output or flag.
  - If the majority is 0, continue; on the wrap, go to DATA.
- **DATA:** shift `DATA_BITS` bits in, LSB first. After the last bit, go to PARITY (if `PARITY_MODE` ≠ 0) or STOP.
- **PARITY:**
  - Even mode: error if the ones count over data plus parity bit is odd.
  - Odd mode: error if that count is even.
- **STOP:**
  - Sample each stop bit; any 0 sets frame error.
  - The frame completes at the M+1 decision of the last stop bit; then go directly to IDLE. This early exit tolerates baud mismatch.
- **Break:** the data is all zero, the parity bit (if any) is 0, and the first stop bit is 0.
  - Pulse `rx_break`; do not deliver the frame.
  - Enter BREAK_WAIT, which returns to IDLE on the first `sample_tick` with `rxs` = 1.
- **Output register (on frame complete, non-break):**
  - If `rx_valid` = 0, or `rx_valid`&`rx_ready` in the same cycle: load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid` = 1.
  - Otherwise, keep the old contents and pulse `overrun` for 1 cycle.
- `rx_valid` clears on the cycle after `rx_valid`&`rx_ready` unless a new frame loads in that same cycle.
- **Reset (any time, including mid-frame):** forces IDLE and clears `cnt`, the shift register and all outputs.

## Timing
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `rx_break` = 0, `rx_busy` = 0.
- **Input latency:** `rx` reaches `rxs` 2 clocks later. The start is recognised on the first `sample_tick` that sees `rxs` = 0.
- **Output latency:** `rx_valid` rises 1 clock after the `sample_tick` at the last stop bit's M+1 decision.
- **Pulses:** `overrun` and `rx_break` are high for exactly 1 clock.
- **Busy:** `rx_busy` rises the clock after start detection and falls the clock after the transition to IDLE.
- **Ticks:** the block never assumes `sample_tick` spacing. A tick held high for consecutive clocks counts once per clock.
- **Handshake:** `rx_ready` is sampled only when `rx_valid` = 1. Data is stable while `rx_valid` = 1 and not yet accepted.

## Test plan
- **Basic 8E1 frame:** default parameters, send 0xA5 with correct even parity and `rx_ready` = 1 → `rx_data` = 0xA5, `rx_valid` pulses for 1 clock, `parity_err` = 0, `frame_err` = 0.
- **Parity error:** send 0x3C with the parity bit inverted → `rx_valid` with `parity_err` = 1. Then `DATA_BITS` = 7, `PARITY_MODE` = 2, `STOP_BITS` = 2, send 0x55 → `rx_data` = 0x55, no errors.
- **Glitch rejection:**
  - Drive `rx` low for 4 ticks mid-idle → no `rx_valid`, and `rx_busy` returns to 0 within M+2 ticks.
  - Send 0x0F with a 1-tick glitch at M of bit 0 → still 0x0F.
- **Overrun:** hold `rx_ready` = 0 and send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses once. Assert `rx_ready` in the cycle a third frame (0x33) completes → `rx_data` = 0x33 and no `overrun`.
- **Break:** hold `rx` low for 2 frame times, then release → `rx_break` pulses once with no `rx_valid`. A following 0x81 frame is received correctly.
- **Reset mid-frame:** assert `rst_n` = 0 during data bit 4 → all outputs 0 and IDLE. Release, then send 0xC3 → `rx_data` = 0xC3 with no errors.
